// File: rtl/sgfilter_pkg.sv
// Shared definitions for the Savitzky-Golay filters: coefficient format and tables,
// controller state encoding and the channel-tag width helper.
package sgfilter_pkg;

    localparam int COEF_W    = 12;
    localparam int COEF_FRAC = 11;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Quadratic smoothing weights round(c_k/norm * 2^11), symmetric about the centre tap.
    localparam coef_t COEF5 [5] = '{-12'sd176, 12'sd702, 12'sd995, 12'sd702, -12'sd176};
    localparam coef_t COEF7 [7] = '{-12'sd195, 12'sd293, 12'sd585, 12'sd683, 12'sd585,
                                    12'sd293, -12'sd195};
    localparam coef_t COEF9 [9] = '{-12'sd186, 12'sd124, 12'sd346, 12'sd479, 12'sd523,
                                    12'sd479, 12'sd346, 12'sd124, -12'sd186};

    typedef enum logic [2:0] {IDLE, SHIFT, MAC, ROUND, HOLD} sg_state_t;

    function automatic int CHAN_W(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    function automatic coef_t coef(input int window, input int k);
        coef_t c;
        c = '0;
        case (window)
            5:       if (k < 5) c = COEF5[k[2:0]];
            7:       if (k < 7) c = COEF7[k[2:0]];
            9:       if (k < 9) c = COEF9[k[3:0]];
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sg_history.sv
// Per-channel sample shift registers and fill counters; one push port and one
// (channel, tap) read port. Tap 0 is the oldest sample in the window.
module sg_history
    import sgfilter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int WINDOW   = 5,
    parameter int CHW      = CHAN_W(CHANNELS),
    parameter int KW       = $clog2(WINDOW)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [CHW-1:0]           push_chan,
    input  logic signed [DATA_W-1:0] push_data,
    input  logic [CHW-1:0]           rd_chan,
    input  logic [KW-1:0]            rd_k,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     full_after_push
);

    localparam int CW = $clog2(WINDOW + 1);

    logic signed [DATA_W-1:0] hist [CHANNELS][WINDOW];
    logic [CW-1:0]            cnt  [CHANNELS];

    // NOTE: the histories are cleared on reset rather than left unknown, so every channel
    // restarts from a defined state and nothing old can leak into a later window.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
                for (int i = 0; i < WINDOW; i++) hist[c][i] <= '0;
            end
        end else if (push) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push_chan == CHW'(c)) begin
                    for (int i = 0; i < WINDOW - 1; i++) hist[c][i] <= hist[c][i+1];
                    hist[c][WINDOW-1] <= push_data;
                    if (cnt[c] != CW'(WINDOW)) cnt[c] <= cnt[c] + CW'(1);
                end
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        rd_data         = '0;
        full_after_push = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_chan == CHW'(c)) begin
                for (int i = 0; i < WINDOW; i++)
                    if (rd_k == KW'(i)) rd_data = hist[c][i];
            end
            if (push_chan == CHW'(c)) full_after_push = (cnt[c] >= CW'(WINDOW - 1));
        end
    end

endmodule

// File: rtl/sgfilter_mc.sv
// Multi-channel Savitzky-Golay quadratic smoother: call/return handshake, one shared
// multiplier sequenced over the window taps, round-to-nearest and saturation.
module sgfilter_mc
    import sgfilter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int WINDOW   = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    input  logic signed [DATA_W-1:0]        in_data,
    input  logic [CHAN_W(CHANNELS)-1:0]     in_chan,
    output logic                            done,
    input  logic                            stall,
    output logic signed [DATA_W-1:0]        returndata,
    output logic [CHAN_W(CHANNELS)-1:0]     return_chan,
    output logic [31:0]                     idx
);

    localparam int CHW   = CHAN_W(CHANNELS);
    localparam int KW    = $clog2(WINDOW);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = DATA_W + COEF_W + $clog2(WINDOW) + 1;
    localparam logic signed [ACC_W:0] SAT_MAX =
        $signed({{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    if (WINDOW != 5 && WINDOW != 7 && WINDOW != 9) begin : g_bad_window
        $error("sgfilter_mc: WINDOW must be 5, 7 or 9");
    end

    sg_state_t state, state_n;

    logic [CHW-1:0]           chan_q;
    logic signed [DATA_W-1:0] data_q;
    logic                     chan_ok;
    logic [KW-1:0]            tap_k;
    logic signed [ACC_W-1:0]  acc;
    logic [31:0]              out_idx [CHANNELS];
    logic [31:0]              cur_idx;

    logic signed [DATA_W-1:0] tap;
    logic                     full_after_push;
    coef_t                    coef_k;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W:0]    rnd, shifted;
    logic signed [DATA_W-1:0] sat;

    sg_history #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .WINDOW   (WINDOW)
    ) u_history (
        .clock           (clock),
        .reset           (reset),
        .push            (state == SHIFT && chan_ok),
        .push_chan       (chan_q),
        .push_data       (data_q),
        .rd_chan         (chan_q),
        .rd_k            (tap_k),
        .rd_data         (tap),
        .full_after_push (full_after_push)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   state_n = (chan_ok && full_after_push) ? MAC : IDLE;
            MAC:     if (tap_k == KW'(WINDOW - 1)) state_n = ROUND;
            ROUND:   state_n = HOLD;
            HOLD:    if (!stall) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == HOLD);
    end

    // Datapath: tap product, round half-up then floor shift, clamp to the sample range.
    always_comb begin
        coef_k  = coef(WINDOW, int'(tap_k));
        prod    = tap * coef_k;
        rnd     = {acc[ACC_W-1], acc} + (ACC_W + 1)'(2 ** (COEF_FRAC - 1));
        shifted = rnd >>> COEF_FRAC;
        if (shifted > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
        else                        sat = shifted[DATA_W-1:0];
        cur_idx = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (chan_q == CHW'(c)) cur_idx = out_idx[c];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chan_q      <= '0;
            data_q      <= '0;
            chan_ok     <= 1'b0;
            tap_k       <= '0;
            acc         <= '0;
            returndata  <= '0;
            return_chan <= '0;
            idx         <= '0;
            for (int c = 0; c < CHANNELS; c++) out_idx[c] <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    data_q  <= in_data;
                    chan_q  <= in_chan;
                    chan_ok <= ({1'b0, in_chan} < (CHW + 1)'(CHANNELS));
                end
                SHIFT: begin
                    acc   <= '0;
                    tap_k <= '0;
                end
                MAC: begin
                    acc   <= acc + ACC_W'(prod);
                    tap_k <= tap_k + KW'(1);
                end
                ROUND: begin
                    returndata  <= sat;
                    return_chan <= chan_q;
                    idx         <= cur_idx;
                    for (int c = 0; c < CHANNELS; c++)
                        if (chan_q == CHW'(c)) out_idx[c] <= out_idx[c] + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sgfilter_mc.sv
// Directed bench for sgfilter_mc (DATA_W=16, WINDOW=5, CHANNELS=3 so that tag 3 is illegal):
// expected returns are queued when a call is issued and compared when done is seen.
module tb_sgfilter_mc;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 3;
    localparam int WINDOW   = 5;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic                     busy;
    logic signed [DATA_W-1:0] in_data = '0;
    logic [1:0]               in_chan = '0;
    logic                     done;
    logic                     stall = 1'b0;
    logic signed [DATA_W-1:0] returndata;
    logic [1:0]               return_chan;
    logic [31:0]              idx;

    typedef struct {
        logic signed [DATA_W-1:0] data;
        logic [1:0]               chan;
        logic [31:0]              idx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   last_lat;

    sgfilter_mc #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .WINDOW(WINDOW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .in_data     (in_data),
        .in_chan     (in_chan),
        .done        (done),
        .stall       (stall),
        .returndata  (returndata),
        .return_chan (return_chan),
        .idx         (idx)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
    endtask

    // Offer one sample; returns #1 after the accepting edge.
    task automatic issue(input logic signed [DATA_W-1:0] d, input logic [1:0] ch);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("issue busy timeout", busy, 0);
        start   = 1'b1;
        in_data = d;
        in_chan = ch;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Wait until the call either produces done or finishes silently.
    task automatic wait_result(input string tag, output bit got);
        got      = 1'b0;
        last_lat = 0;
        for (int n = 0; n < 50; n++) begin
            if (n > 0 || last_lat == 0) begin
                @(posedge clock);
                last_lat++;
                #1;
            end
            if (done) begin
                got = 1'b1;
                return;
            end
            if (!busy) return;
        end
        check({tag, " result timeout"}, 1, 0);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " unexpected return"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, " data"}, returndata, e.data);
        check({tag, " chan"}, return_chan, e.chan);
        check({tag, " idx"}, idx, e.idx);
    endtask

    task automatic do_call(input string tag, input logic signed [DATA_W-1:0] d,
                           input logic [1:0] ch, input bit expect_ret,
                           input logic signed [DATA_W-1:0] ed, input logic [31:0] ei);
        bit   got;
        exp_t e;
        if (expect_ret) begin
            e.data = ed; e.chan = ch; e.idx = ei;
            sb.push_back(e);
        end
        issue(d, ch);
        wait_result(tag, got);
        check({tag, " return present"}, got, expect_ret);
        if (got) begin
            pop_check(tag);
            @(posedge clock);
            #1 check({tag, " done after transfer"}, done, 0);
        end else if (expect_ret && sb.size() > 0) begin
            void'(sb.pop_back());
        end
    endtask

    initial begin
        logic signed [DATA_W-1:0] imp_in  [11];
        logic signed [DATA_W-1:0] imp_exp [11];
        logic signed [DATA_W-1:0] hold_data;
        logic [31:0]              hold_idx;
        bit                       got;
        int                       seen;

        imp_in  = '{0, 0, 0, 0, 0, 1000, 0, 0, 0, 0, 0};
        imp_exp = '{0, 0, 0, 0, 0, -86, 343, 486, 343, -86, 0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset returndata", returndata, 0);
        check("reset return_chan", return_chan, 0);
        check("reset idx", idx, 0);

        // 1. Priming and constant input, plus call-to-done latency
        for (int i = 0; i < 8; i++) begin
            do_call($sformatf("t1 call%0d", i + 1), 1000, 0, i >= 4, 1000, i - 4);
            if (i == 4) check("t1 latency", last_lat, WINDOW + 2);
        end

        // 2. Impulse response, centred sample by sample
        apply_reset();
        for (int i = 0; i < 11; i++)
            do_call($sformatf("t2 call%0d", i + 1), imp_in[i], 0, i >= 4, imp_exp[i], i - 4);

        // 3. Saturation at both rails
        apply_reset();
        do_call("t3 p1", -32768, 0, 0, 0, 0);
        do_call("t3 p2",  32767, 0, 0, 0, 0);
        do_call("t3 p3",  32767, 0, 0, 0, 0);
        do_call("t3 p4",  32767, 0, 0, 0, 0);
        do_call("t3 pos", -32768, 0, 1, 32767, 0);
        do_call("t3 n1",  32767, 1, 0, 0, 0);
        do_call("t3 n2", -32768, 1, 0, 0, 0);
        do_call("t3 n3", -32768, 1, 0, 0, 0);
        do_call("t3 n4", -32768, 1, 0, 0, 0);
        do_call("t3 neg", 32767, 1, 1, -32768, 0);

        // 4. Interleaved channels keep separate histories and indices
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            do_call($sformatf("t4 ch0 call%0d", i + 1),  100, 0, i >= 4,  100, i - 4);
            do_call($sformatf("t4 ch1 call%0d", i + 1), -200, 1, i >= 4, -200, i - 4);
        end

        // 5. Backpressure: outputs hold and a start during the stall is ignored
        stall = 1'b1;
        issue(100, 0);
        wait_result("t5", got);
        check("t5 return present", got, 1);
        hold_data = returndata;
        hold_idx  = idx;
        check("t5 held data", hold_data, 100);
        check("t5 held idx", hold_idx, 3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c == 3) begin
                start   = 1'b1;
                in_data = 30000;
                in_chan = 0;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            check($sformatf("t5 stall%0d done", c), done, 1);
            check($sformatf("t5 stall%0d data", c), returndata, 100);
            check($sformatf("t5 stall%0d idx", c), idx, 3);
            check($sformatf("t5 stall%0d busy", c), busy, 1);
        end
        start = 1'b0;
        stall = 1'b0;
        @(posedge clock);
        #1 check("t5 done after release", done, 0);
        for (int i = 0; i < 4; i++)
            do_call($sformatf("t5 after%0d", i), 100, 0, 1, 100, 4 + i);

        // 6. Reset during MAC drops the result and re-primes the histories
        issue(-200, 1);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("t6 done after reset", done, 0);
        check("t6 busy after reset", busy, 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clock);
            #1 if (done) seen++;
        end
        check("t6 no done after reset", seen, 0);
        sb.delete();
        for (int i = 0; i < 5; i++)
            do_call($sformatf("t6 reprime%0d", i + 1), -200, 1, i == 4, -200, 0);

        // Illegal channel tag: accepted, busy for a cycle, no return, no history change
        issue(5, 3);
        check("t6 illegal busy pulse", busy, 1);
        wait_result("t6 illegal", got);
        check("t6 illegal no done", got, 0);
        do_call("t6 ch1 after illegal", -200, 1, 1, -200, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
